conv_y_collector: RTL and testbench

- Receiving end of the convolution output stream: slave on the y valid/ready interface (pairs with the convolution block's m_valid_y / m_ready_y / m_data_out_y).
- Captures one frame of Y_SIZE signed results into a local buffer and keeps a running sum and running maximum.
- Flags frame completion and exposes the buffer through a registered read port for host/checker access.

---
 rtl/conv_y_collector_if.sv | 21 ++
 rtl/conv_y_collector.sv | 104 ++++++++++
 tb/tb_conv_y_collector.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_y_collector_if.sv
// Valid/ready stream carrying signed convolution results from the convolution block
// to its collector.
interface conv_y_collector_if #(
  parameter int DATA_WIDTH = 21
);
  logic                         s_valid_y;
  logic signed [DATA_WIDTH-1:0] s_data_in_y;
  logic                         s_ready_y;

  modport master (
    output s_valid_y,
    output s_data_in_y,
    input  s_ready_y
  );

  modport slave (
    input  s_valid_y,
    input  s_data_in_y,
    output s_ready_y
  );
endinterface

// File: rtl/conv_y_collector.sv
// Collects one frame of signed convolution results into a buffer while tracking the
// running sum and maximum, then holds until cleared.
module conv_y_collector #(
  parameter int DATA_WIDTH = 21,
  parameter int Y_SIZE     = 97,
  parameter int ADDR_WIDTH = $clog2(Y_SIZE),
  parameter int SUM_WIDTH  = DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  conv_y_collector_if.slave            y_if,
  input  logic                         stall,
  input  logic                         clear,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]          count,
  output logic signed [SUM_WIDTH-1:0]  sum_out,
  output logic signed [DATA_WIDTH-1:0] max_out,
  output logic                         done
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DONE    = 1'b1;

  localparam logic [ADDR_WIDTH:0]          DEPTH    = (ADDR_WIDTH+1)'(Y_SIZE);
  localparam logic [ADDR_WIDTH:0]          LAST_IDX = (ADDR_WIDTH+1)'(Y_SIZE - 1);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [0:0]                   state_q, state_d;
  logic [ADDR_WIDTH:0]          count_q, count_d;
  logic signed [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic signed [DATA_WIDTH-1:0] mem_q [Y_SIZE];

  logic                         ready;
  logic                         accept;
  logic signed [SUM_WIDTH-1:0]  sample_ext;

  assign ready      = (state_q == ST_COLLECT) && !stall && !clear;
  assign accept     = y_if.s_valid_y && ready;
  assign sample_ext = {{ADDR_WIDTH{y_if.s_data_in_y[DATA_WIDTH-1]}}, y_if.s_data_in_y};

  // Clear takes priority; it also drops ready, so it never coincides with an accept.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    max_d   = max_q;
    if (clear) begin
      state_d = ST_COLLECT;
      count_d = '0;
      sum_d   = '0;
      max_d   = MOST_NEG;
    end else if (accept) begin
      count_d = count_q + 1'b1;
      sum_d   = sum_q + sample_ext;
      if (y_if.s_data_in_y > max_q) begin
        max_d = y_if.s_data_in_y;
      end
      if (count_q == LAST_IDX) begin
        state_d = ST_DONE;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < DEPTH) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_COLLECT;
      count_q   <= '0;
      sum_q     <= '0;
      max_q     <= MOST_NEG;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffer is deliberately unreset; a same-address read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[count_q[ADDR_WIDTH-1:0]] <= y_if.s_data_in_y;
    end
  end

  assign y_if.s_ready_y = ready;
  assign rd_data        = rd_data_q;
  assign count          = count_q;
  assign sum_out        = sum_q;
  assign max_out        = max_q;
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_y_collector.sv
// Randomized self-checking bench for conv_y_collector: a frame-level reference model
// is compared against the DUT on every falling clock edge.
module tb_conv_y_collector;

  localparam int DW    = 21;
  localparam int YS    = 97;
  localparam int AW    = $clog2(YS);
  localparam int SW    = DW + AW;
  localparam int NEG_MAX = -(1 << (DW - 1));

  logic                 clk;
  logic                 reset;
  logic                 stall;
  logic                 clear;
  logic [AW-1:0]        rd_addr;
  wire signed [DW-1:0]  rd_data;
  wire [AW:0]           count;
  wire signed [SW-1:0]  sum_out;
  wire signed [DW-1:0]  max_out;
  wire                  done;

  conv_y_collector_if #(.DATA_WIDTH(DW)) yif ();

  conv_y_collector #(
    .DATA_WIDTH(DW),
    .Y_SIZE    (YS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .y_if   (yif),
    .stall  (stall),
    .clear  (clear),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .count  (count),
    .sum_out(sum_out),
    .max_out(max_out),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference state
  int     m_count;
  longint m_sum;
  int     m_max;
  bit     m_done;
  int     m_rd;
  bit     m_rd_known;
  int     m_buf   [YS];
  bit     m_known [YS];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_sum      = 0;
    m_max      = NEG_MAX;
    m_done     = 1'b0;
    m_rd       = 0;
    m_rd_known = 1'b1;
  endtask

  task automatic model_step();
    int  d;
    bit  rdy;
    rdy = !m_done && !stall && !clear;
    d   = int'($signed(yif.s_data_in_y));
    if (int'(rd_addr) < YS) begin
      m_rd       = m_buf[rd_addr];
      m_rd_known = m_known[rd_addr];
    end else begin
      m_rd       = 0;
      m_rd_known = 1'b1;
    end
    if (clear) begin
      model_reset();
      m_rd_known = (int'(rd_addr) < YS) ? m_known[rd_addr] : 1'b1;
      m_rd       = (int'(rd_addr) < YS) ? m_buf[rd_addr] : 0;
    end else if (yif.s_valid_y && rdy) begin
      m_buf[m_count]   = d;
      m_known[m_count] = 1'b1;
      m_count++;
      m_sum += d;
      if (d > m_max) m_max = d;
      if (m_count == YS) m_done = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < YS; i++) begin
      m_known[i] = 1'b0;
      m_buf[i]   = 0;
    end
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("count", count, m_count);
      check("sum_out", sum_out, m_sum);
      check("max_out", max_out, m_max);
      check("done", done, m_done);
      check("s_ready_y", yif.s_ready_y, !m_done && !stall && !clear);
      if (m_rd_known) check("rd_data", rd_data, m_rd);
    end
  end

  function automatic int sample_of(input int mode, input int k);
    case (mode)
      0:       return k;
      1:       return -(k + 1);
      2:       return k * 1000 - 48000;
      3:       return (1 << (DW - 1)) - 1;
      default: return NEG_MAX;
    endcase
  endfunction

  // Upstream producer: holds valid/data while not accepted, random gaps and stalls.
  task automatic applyStimulus(input int mode, input int stall_pct, input int gap_pct,
                               input int clear_after, input int stop_at, input int budget,
                               output int cycles);
    int k;
    int acc;
    bit hs;
    bit cleared;
    k = 0; acc = 0; hs = 1'b0; cleared = 1'b0; cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      if (hs) begin
        k++;
        acc++;
      end
      if (m_done || (stop_at >= 0 && acc == stop_at)) break;
      if (cycles >= budget) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL frame_budget: got %0d accepts after %0d cycles, expected frame done", acc, cycles);
        break;
      end
      cycles++;
      clear = 1'b0;
      if (!(yif.s_valid_y && !hs)) begin
        yif.s_valid_y   = ($urandom_range(99) >= gap_pct);
        yif.s_data_in_y = DW'(sample_of(mode, k));
      end
      stall = ($urandom_range(99) < stall_pct);
      if (clear_after >= 0 && !cleared && acc == clear_after) begin
        clear           = 1'b1;
        yif.s_valid_y   = 1'b1;
        yif.s_data_in_y = DW'(sample_of(mode, k));
        cleared         = 1'b1;
      end
      rd_addr = AW'($urandom_range(127));
      @(negedge clk);
      hs = yif.s_valid_y && yif.s_ready_y;
    end
    yif.s_valid_y = 1'b0;
    clear         = 1'b0;
    stall         = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int addr, input int exp);
    @(posedge clk);
    #1;
    rd_addr = AW'(addr);
    @(posedge clk);
    @(negedge clk);
    check(name, rd_data, exp);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  int cyc;

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    clear           = 1'b0;
    rd_addr         = '0;
    yif.s_valid_y   = 1'b0;
    yif.s_data_in_y = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_sum", sum_out, 0);
    check("reset_max", max_out, -1048576);
    check("reset_done", done, 0);
    check("reset_rd_data", rd_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Full-rate ramp frame
    applyStimulus(0, 0, 0, -1, -1, 300, cyc);
    check("ramp_cycles", cyc, 97);
    @(negedge clk);
    check("ramp_count", count, 97);
    check("ramp_sum", sum_out, 4656);
    check("ramp_max", max_out, 96);
    check("ramp_done", done, 1);
    check("ramp_ready", yif.s_ready_y, 0);
    @(posedge clk);
    #1 yif.s_valid_y = 1'b1;
    repeat (3) @(posedge clk);
    #1 yif.s_valid_y = 1'b0;
    check("done_hold_count", count, 97);

    // Negative frame and read port
    pulse_clear();
    applyStimulus(1, 0, 0, -1, -1, 300, cyc);
    @(negedge clk);
    check("neg_sum", sum_out, -4753);
    check("neg_max", max_out, -1);
    checkOutput("rd_addr5", 5, -6);
    checkOutput("rd_addr100", 100, 0);

    // Backpressure with gaps
    pulse_clear();
    applyStimulus(2, 50, 30, -1, -1, 3000, cyc);
    @(negedge clk);
    check("bp_sum", sum_out, 0);
    check("bp_max", max_out, 48000);
    for (int i = 0; i < YS; i++) checkOutput("bp_buf", i, i * 1000 - 48000);

    // Mid-frame clear with pending sample
    pulse_clear();
    applyStimulus(0, 0, 0, 40, -1, 400, cyc);
    @(negedge clk);
    check("clr_count", count, 97);
    check("clr_sum", sum_out, 8536);
    check("clr_max", max_out, 136);
    checkOutput("clr_buf0", 0, 40);
    checkOutput("clr_buf96", 96, 136);

    // Asynchronous reset mid-frame
    pulse_clear();
    applyStimulus(0, 0, 0, -1, 60, 300, cyc);
    check("pre_reset_count", count, 60);
    #2 reset = 1'b0;
    #1;
    check("areset_count", count, 0);
    check("areset_sum", sum_out, 0);
    check("areset_max", max_out, -1048576);
    check("areset_done", done, 0);
    check("areset_rd_data", rd_data, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(2, 30, 20, -1, -1, 3000, cyc);
    @(negedge clk);
    check("post_reset_sum", sum_out, 0);
    check("post_reset_max", max_out, 48000);

    // Extremes
    pulse_clear();
    applyStimulus(3, 0, 0, -1, -1, 300, cyc);
    @(negedge clk);
    check("pos_ext_sum", sum_out, 101711775);
    check("pos_ext_max", max_out, 1048575);
    pulse_clear();
    applyStimulus(4, 0, 0, -1, -1, 300, cyc);
    @(negedge clk);
    check("neg_ext_sum", sum_out, -101711872);
    check("neg_ext_max", max_out, -1048576);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
